// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one byte-wide, single-port, synchronous-read memory between the
// instruction-fetch requester (10-byte window) and the data-memory requester
// (8-byte read or write). Each transaction becomes a run of one-byte memory
// beats. Read bytes are assembled into the requester's word, write words are
// split into bytes, and start addresses are range-checked before any beat is
// issued.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_if_req, i_if_addr    fetch request and start address (held until ready)
//   o_if_ready, o_if_err   one-cycle fetch completion pulse, range error flag
//   o_if_inst              fetched bytes, byte at i_if_addr in the top byte
//   i_dm_req, i_dm_we      data request, 1 = write
//   i_dm_addr, i_dm_wdata  data start address, little-endian write word
//   o_dm_ready, o_dm_err   one-cycle data completion pulse, range error flag
//   o_dm_rdata             little-endian read word
//   o_busy                 arbiter is not idle
//   o_mem_en, o_mem_we     memory beat enable, beat is a write
//   o_mem_addr             beat byte address
//   o_mem_wdata            beat write byte
//   i_mem_rdata            read byte, valid the cycle after a read beat
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int MEM_BYTES   = 601,
    parameter int FETCH_BYTES = 10,
    parameter int DATA_BYTES  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_if_req,
    input  logic [ADDR_W-1:0]        i_if_addr,
    output logic                     o_if_ready,
    output logic                     o_if_err,
    output logic [FETCH_BYTES*8-1:0] o_if_inst,
    input  logic                     i_dm_req,
    input  logic                     i_dm_we,
    input  logic [ADDR_W-1:0]        i_dm_addr,
    input  logic [DATA_BYTES*8-1:0]  i_dm_wdata,
    output logic                     o_dm_ready,
    output logic                     o_dm_err,
    output logic [DATA_BYTES*8-1:0]  o_dm_rdata,
    output logic                     o_busy,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [7:0]               o_mem_wdata,
    input  logic [7:0]               i_mem_rdata
);

    localparam int FW = FETCH_BYTES * 8;
    localparam int DW = DATA_BYTES * 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DREAD  = 3'd2;
    localparam logic [2:0] S_DWRITE = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // Highest legal start address for each requester; anything above it
    // (including addresses near 2^64) would run past the implemented memory.
    localparam logic [ADDR_W-1:0] LIM_FETCH = ADDR_W'(MEM_BYTES - FETCH_BYTES);
    localparam logic [ADDR_W-1:0] LIM_DATA  = ADDR_W'(MEM_BYTES - DATA_BYTES);
    localparam logic [3:0]        LAST_FETCH = 4'(FETCH_BYTES - 1);
    localparam logic [3:0]        LAST_DATA  = 4'(DATA_BYTES - 1);

    // Byte idx of a little-endian word.
    function automatic logic [7:0] byte_sel(input logic [DW-1:0] word, input logic [3:0] idx);
        logic [DW-1:0] shifted;
        shifted = word >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

    // Reverse byte order of a data word.
    function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] word);
        logic [DW-1:0] swapped;
        swapped = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            swapped[8*k +: 8] = word[DW-8-8*k +: 8];
        end
        return swapped;
    endfunction

    // State and transaction context
    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_we;
    logic [DW-1:0]     r_wdata;
    logic              r_is_data;
    logic              r_err;
    // Shift register of captured read bytes, earliest byte highest.
    logic [FW-9:0]     r_buf;

    // Registered outputs
    logic              r_if_ready;
    logic              r_if_err;
    logic [FW-1:0]     r_if_inst;
    logic              r_dm_ready;
    logic              r_dm_err;
    logic [DW-1:0]     r_dm_rdata;
    logic              r_busy;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    // Next-state / next-beat wires
    logic [2:0]        w_state_n;
    logic [3:0]        w_cnt_n;
    logic [3:0]        w_cnt_inc;
    logic [3:0]        w_last;
    logic              w_grant_data;
    logic              w_grant_fetch;
    logic              w_legal;
    logic              w_mem_en_n;
    logic              w_mem_we_n;
    logic [ADDR_W-1:0] w_mem_addr_n;
    logic [7:0]        w_mem_wdata_n;
    logic              w_to_resp;
    logic              w_to_data;
    logic              w_to_err;
    logic [FW-1:0]     w_fetch_word;
    logic [DW-1:0]     w_data_word;
    logic              w_if_live;
    logic              w_dm_live;
    logic              w_capture;

    assign w_cnt_inc    = r_cnt + 4'd1;
    // In RESP the final byte is still on i_mem_rdata, so the completed word
    // is formed from the buffer plus the live byte.
    assign w_fetch_word = {r_buf, i_mem_rdata};
    assign w_data_word  = byte_swap({r_buf[DW-9:0], i_mem_rdata});
    assign w_if_live    = (r_state == S_RESP) && !r_is_data;
    assign w_dm_live    = (r_state == S_RESP) && r_is_data && !r_we;
    // Beat cnt-1's byte arrives during beat cnt.
    assign w_capture    = ((r_state == S_FETCH) || (r_state == S_DREAD)) && (r_cnt != 4'd0);

    // Entry into RESP: from IDLE on an illegal grant, or after the last beat.
    assign w_to_resp = (w_state_n == S_RESP) && (r_state != S_RESP);
    assign w_to_data = (r_state == S_IDLE) ? w_grant_data : r_is_data;
    assign w_to_err  = (r_state == S_IDLE) && !w_legal;

    // Arbitration, sequencing and next memory-beat values.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_last        = LAST_FETCH;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_legal       = 1'b0;
        w_mem_en_n    = 1'b0;
        w_mem_we_n    = 1'b0;
        w_mem_addr_n  = '0;
        w_mem_wdata_n = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = 4'd0;
                // Data has fixed priority: the memory stage holds the older instruction.
                if (i_dm_req) begin
                    w_grant_data = 1'b1;
                    w_legal      = (i_dm_addr <= LIM_DATA);
                    if (w_legal) begin
                        w_state_n     = i_dm_we ? S_DWRITE : S_DREAD;
                        w_mem_en_n    = 1'b1;
                        w_mem_we_n    = i_dm_we;
                        w_mem_addr_n  = i_dm_addr;
                        w_mem_wdata_n = i_dm_we ? i_dm_wdata[7:0] : 8'h00;
                    end else begin
                        w_state_n = S_RESP;
                    end
                end else if (i_if_req) begin
                    w_grant_fetch = 1'b1;
                    w_legal       = (i_if_addr <= LIM_FETCH);
                    if (w_legal) begin
                        w_state_n    = S_FETCH;
                        w_mem_en_n   = 1'b1;
                        w_mem_addr_n = i_if_addr;
                    end else begin
                        w_state_n = S_RESP;
                    end
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_FETCH, S_DREAD, S_DWRITE: begin
                w_last = (r_state == S_FETCH) ? LAST_FETCH : LAST_DATA;
                if (r_cnt == w_last) begin
                    w_state_n = S_RESP;
                    w_cnt_n   = 4'd0;
                end else begin
                    w_cnt_n       = w_cnt_inc;
                    w_mem_en_n    = 1'b1;
                    w_mem_we_n    = (r_state == S_DWRITE);
                    w_mem_addr_n  = r_base + ADDR_W'(w_cnt_inc);
                    w_mem_wdata_n = (r_state == S_DWRITE) ? byte_sel(r_wdata, w_cnt_inc) : 8'h00;
                end
            end
            S_RESP: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 4'd0;
            end
        endcase
    end

    // State, counter, busy flag and memory beat registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_busy      <= (w_state_n != S_IDLE);
            r_mem_en    <= w_mem_en_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
        end
    end

    // Transaction context latched at grant; requester inputs are ignored afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_is_data <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_grant_data || w_grant_fetch) begin
            r_base    <= w_grant_data ? i_dm_addr : i_if_addr;
            r_we      <= w_grant_data && i_dm_we;
            r_wdata   <= w_grant_data ? i_dm_wdata : '0;
            r_is_data <= w_grant_data;
            r_err     <= !w_legal;
        end
    end

    // Read-byte assembly buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf <= '0;
        end else if (w_grant_data || w_grant_fetch) begin
            r_buf <= '0;
        end else if (w_capture) begin
            r_buf <= {r_buf[FW-17:0], i_mem_rdata};
        end
    end

    // Ready pulses and error flags, set on the edge entering RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_ready <= 1'b0;
            r_if_err   <= 1'b0;
            r_dm_ready <= 1'b0;
            r_dm_err   <= 1'b0;
        end else begin
            r_if_ready <= w_to_resp && !w_to_data;
            r_dm_ready <= w_to_resp && w_to_data;
            if (w_to_resp && !w_to_data) begin
                r_if_err <= w_to_err;
            end
            if (w_to_resp && w_to_data) begin
                r_dm_err <= w_to_err;
            end
        end
    end

    // Held read data, refreshed at the end of a read's RESP cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_inst  <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_if_live) begin
                r_if_inst <= r_err ? '0 : w_fetch_word;
            end
            if (w_dm_live) begin
                r_dm_rdata <= r_err ? '0 : w_data_word;
            end
        end
    end

    // During RESP the completed word is presented directly so it is valid
    // alongside the ready pulse; the held register covers every other cycle.
    assign o_if_inst   = w_if_live ? (r_err ? '0 : w_fetch_word) : r_if_inst;
    assign o_dm_rdata  = w_dm_live ? (r_err ? '0 : w_data_word) : r_dm_rdata;
    assign o_if_ready  = r_if_ready;
    assign o_if_err    = r_if_err;
    assign o_dm_ready  = r_dm_ready;
    assign o_dm_err    = r_dm_err;
    assign o_busy      = r_busy;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for mem_port_arbiter: a byte memory model answers the DUT's beats,
// and a transaction-level reference (byte array plus start-address rule)
// predicts latency, error flags, assembled words and the beat sequence.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MEMB = 601;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic        if_err;
    logic [79:0] if_inst;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ready;
    logic        dm_err;
    logic [63:0] dm_rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ready  (if_ready),
        .o_if_err    (if_err),
        .o_if_inst   (if_inst),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_ready  (dm_ready),
        .o_dm_err    (dm_err),
        .o_dm_rdata  (dm_rdata),
        .o_busy      (busy),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int oob   = 0;

    logic [7:0] env_mem [0:MEMB-1];   // memory the DUT actually talks to
    logic [7:0] ref_mem [0:MEMB-1];   // reference contents

    int          q_cyc  [$];
    logic [63:0] q_addr [$];
    logic        q_we   [$];
    logic [7:0]  q_wd   [$];

    // reference view of held outputs
    logic [79:0] m_if_inst;
    logic        m_if_err;
    logic [63:0] m_dm_rdata;
    logic        m_dm_err;

    // Synchronous-read byte memory plus beat logger; garbage when not reading.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(mem_addr);
            q_we.push_back(mem_we);
            q_wd.push_back(mem_wdata);
            if (mem_addr >= 64'(MEMB)) begin
                oob <= oob + 1;
                mem_rdata <= 8'($urandom);
            end else if (mem_we) begin
                env_mem[int'(mem_addr)] <= mem_wdata;
                mem_rdata <= 8'($urandom);
            end else begin
                mem_rdata <= env_mem[int'(mem_addr)];
            end
        end else begin
            mem_rdata <= 8'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_illegal(input logic [63:0] a, input int n);
        return ({8'h00, a} + 72'(n)) > 72'(MEMB);
    endfunction

    function automatic logic [79:0] ref_fetch(input logic [63:0] a);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r = {r[71:0], ref_mem[int'(a) + k]};
        return r;
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[int'(a) + k];
        return r;
    endfunction

    task automatic set_byte(input int a, input logic [7:0] b);
        env_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic model_reset();
        m_if_inst  = '0;
        m_if_err   = 1'b0;
        m_dm_rdata = '0;
        m_dm_err   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 80'({if_ready, if_err, dm_ready, dm_err, busy, mem_en, mem_we}), 80'd0);
        chk({tag, "_inst"}, if_inst, 80'd0);
        chk({tag, "_rdata"}, 80'(dm_rdata), 80'd0);
        chk({tag, "_mbus"}, 80'({mem_addr, mem_wdata}), 80'd0);
    endtask

    // One complete transaction from an idle arbiter, checked end to end.
    task automatic run_txn(input bit is_data, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata);
        int n;
        int g0;
        int nb;
        bit err;
        nb  = is_data ? 8 : 10;
        err = ref_illegal(addr, nb);
        if (!is_data) begin
            m_if_err  = err;
            m_if_inst = err ? 80'd0 : ref_fetch(addr);
        end else begin
            m_dm_err = err;
            if (!we) begin
                m_dm_rdata = err ? 64'd0 : ref_read(addr);
            end else if (!err) begin
                for (int k = 0; k < 8; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
            end
        end
        q_cyc.delete(); q_addr.delete(); q_we.delete(); q_wd.delete();
        if (is_data) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        g0 = cyc;
        n  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n = i;
            if (if_ready || dm_ready) break;
        end
        chk("latency", 80'(n), err ? 80'd1 : 80'(nb + 1));
        chk("if_ready", 80'(if_ready), 80'(!is_data));
        chk("dm_ready", 80'(dm_ready), 80'(is_data));
        chk("if_err", 80'(if_err), 80'(m_if_err));
        chk("dm_err", 80'(dm_err), 80'(m_dm_err));
        chk("if_inst", if_inst, m_if_inst);
        chk("dm_rdata", 80'(dm_rdata), 80'(m_dm_rdata));
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        chk("ready_pulse", 80'({if_ready, dm_ready}), 80'd0);
        chk("busy_idle", 80'(busy), 80'd0);
        chk("if_inst_hold", if_inst, m_if_inst);
        chk("dm_rdata_hold", 80'(dm_rdata), 80'(m_dm_rdata));
        chk("if_err_hold", 80'(if_err), 80'(m_if_err));
        chk("dm_err_hold", 80'(dm_err), 80'(m_dm_err));
        chk("beat_count", 80'(q_addr.size()), err ? 80'd0 : 80'(nb));
        for (int k = 0; k < q_addr.size() && k < nb; k++) begin
            chk($sformatf("beat_addr%0d", k), 80'(q_addr[k]), 80'(addr + 64'(k)));
            chk($sformatf("beat_cyc%0d", k), 80'(q_cyc[k]), 80'(g0 + 1 + k));
            chk($sformatf("beat_we%0d", k), 80'(q_we[k]), 80'(is_data && we));
            if (is_data && we) chk($sformatf("beat_wd%0d", k), 80'(q_wd[k]), 80'(wdata[8*k +: 8]));
        end
        chk("no_oob", 80'(oob), 80'd0);
    endtask

    initial begin
        int n;
        int kind;
        int sel;
        int nb;
        bit seen;
        logic [63:0] a;
        logic [63:0] wd;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < MEMB; i++) set_byte(i, 8'($urandom));
        model_reset();

        // reset, then idle with no requests
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_mem_en", 80'(mem_en), 80'd0);
            chk("idle_busy", 80'(busy), 80'd0);
        end

        // directed fetch at 0
        set_byte(0, 8'h30); set_byte(1, 8'hF2); set_byte(2, 8'h0A);
        for (int i = 3; i < 10; i++) set_byte(i, 8'h00);
        run_txn(1'b0, 1'b0, 64'h0, 64'h0);
        chk("fetch0_const", if_inst, 80'h30F20A00000000000000);

        // reset in the middle of a cycle with non-zero held outputs
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 80'({mem_en, busy}), 80'd0);

        // write then read back
        run_txn(1'b1, 1'b1, 64'h100, 64'h1122334455667788);
        chk("wr_byte0", 80'(env_mem[256]), 80'h88);
        chk("wr_byte7", 80'(env_mem[263]), 80'h11);
        run_txn(1'b1, 1'b0, 64'h100, 64'h0);
        chk("rd_const", 80'(dm_rdata), 80'h1122334455667788);

        // simultaneous requests: data first, fetch after one IDLE cycle
        m_dm_rdata = ref_read(64'h20);  m_dm_err = 1'b0;
        m_if_inst  = ref_fetch(64'h50); m_if_err = 1'b0;
        q_cyc.delete(); q_addr.delete(); q_we.delete(); q_wd.delete();
        if_req = 1'b1; if_addr = 64'h50;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (dm_ready || if_ready) break;
        end
        chk("both_dm_lat", 80'(n), 80'd9);
        chk("both_dm_first", 80'({dm_ready, if_ready}), 80'b10);
        chk("both_dm_rdata", 80'(dm_rdata), 80'(m_dm_rdata));
        dm_req = 1'b0;
        @(negedge clk);
        n++;
        chk("both_idle_gap", 80'({busy, if_ready}), 80'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (if_ready) break;
        end
        chk("both_if_lat", 80'(n), 80'd21);
        chk("both_if_inst", if_inst, m_if_inst);
        if_req = 1'b0;
        @(negedge clk);
        chk("both_beats", 80'(q_addr.size()), 80'd18);
        if (q_addr.size() == 18) begin
            chk("both_first_addr", 80'(q_addr[0]), 80'h20);
            chk("both_fetch_addr", 80'(q_addr[8]), 80'h50);
        end

        // range boundaries
        run_txn(1'b1, 1'b0, 64'd593, 64'h0);
        run_txn(1'b1, 1'b0, 64'd594, 64'h0);
        chk("dm594_rdata", 80'(dm_rdata), 80'd0);
        chk("dm594_err", 80'(dm_err), 80'd1);
        run_txn(1'b1, 1'b1, 64'd593, {$urandom, $urandom});
        run_txn(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0);
        chk("ifwrap_err", 80'(if_err), 80'd1);
        run_txn(1'b0, 1'b0, 64'd591, 64'h0);
        run_txn(1'b0, 1'b0, 64'd592, 64'h0);

        // reset during a write after three beats
        a  = 64'h40;
        wd = {$urandom, $urandom};
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = a; dm_wdata = wd;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_mem_en", 80'({mem_en, mem_we, busy, dm_ready}), 80'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        for (int k = 0; k < 3; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | dm_ready;
        end
        rst_n = 1'b1;
        chk("abort_no_ready", 80'(seen), 80'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("abort_mem%0d", k), 80'(env_mem[int'(a) + k]), 80'(ref_mem[int'(a) + k]));
        end
        @(negedge clk);
        run_txn(1'b1, 1'b0, a, 64'h0);
        run_txn(1'b1, 1'b1, a, {$urandom, $urandom});
        run_txn(1'b1, 1'b0, a, 64'h0);

        // randomized transactions
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            nb   = (kind == 0) ? 10 : 8;
            sel  = $urandom_range(0, 9);
            if (sel < 7)       a = 64'($urandom_range(0, MEMB - nb));
            else if (sel == 7) a = 64'(MEMB - nb + $urandom_range(0, 1));
            else if (sel == 8) a = {$urandom, $urandom};
            else               a = 64'h0;
            if (kind == 2 && ref_illegal(a, nb)) a = 64'(MEMB - nb);
            wd = {$urandom, $urandom};
            run_txn(kind != 0, kind == 2, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single byte-wide, single-port unified memory between two requesters: instruction fetch (10-byte Y86-64 instruction window) and data memory (8-byte read or write).
- Serializes each transaction into per-byte memory beats, assembles or splits words, and range-checks addresses.
- Sits between the fetch/memory stages and the shared byte memory. Lets the processor drop the dual-ported combinational memory model in favour of a realistic single port.

Parameters:
- ADDR_W, 64, address width of all address ports.
- MEM_BYTES, 601, number of implemented memory bytes; valid byte addresses are 0..MEM_BYTES-1.
- FETCH_BYTES, 10, bytes per instruction fetch.
- DATA_BYTES, 8, bytes per data access.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; hold with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch start byte address
- if_ready  out  1  one-cycle completion pulse for fetch
- if_err  out  1  fetch out of range; valid with if_ready, held afterwards
- if_inst  out  80  fetched bytes; byte at if_addr in [79:72], addr+9 in [7:0]
- dm_req  in  1  data request; hold with dm_we/dm_addr/dm_wdata stable until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data start byte address
- dm_wdata  in  64  write data, little-endian: byte at addr+k = bits [8k+7:8k]
- dm_ready  out  1  one-cycle completion pulse for data
- dm_err  out  1  data address out of range; valid with dm_ready, held afterwards
- dm_rdata  out  64  read data, little-endian as dm_wdata
- busy  out  1  state is not IDLE
- mem_en  out  1  memory beat enable
- mem_we  out  1  beat is a write (only with mem_en)
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  8  beat write byte
- mem_rdata  in  8  read byte, valid the cycle after a read beat (synchronous read)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the byte counter clears.
  - All outputs go to 0, including if_inst, dm_rdata and both err flags.
  - mem_en and mem_we fall immediately, not at the next edge.
  - Reset mid-write truncates the transaction; bytes already written remain. No ready pulse is produced for an aborted transaction.
- States: IDLE, FETCH, DREAD, DWRITE, RESP.
- IDLE grant rules:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: data wins (fixed priority; the memory stage is older). Fetch is served next.
  - On grant, latch addr, we and wdata, clear the counter, and range-check.
- Range check: legal iff addr <= MEM_BYTES-N (unsigned 64-bit compare, N = 10 or 8). Addresses near 2^64 are therefore illegal; there is no wrap-around.
  - Illegal: go straight to RESP with err=1, issue no memory beats, and zero the data output.
- FETCH / DREAD:
  - Each cycle drive mem_en=1, mem_we=0, mem_addr = base+cnt; cnt runs 0..N-1.
  - In the same cycle, capture mem_rdata for beat cnt-1 (from cnt=1 onward).
  - After beat N-1, go to RESP.
- DWRITE:
  - Each cycle drive mem_en=1, mem_we=1, mem_addr = base+cnt, mem_wdata = wdata[8cnt+7:8cnt] for cnt 0..7.
  - After beat 7, go to RESP.
- RESP:
  - For reads, capture the final byte.
  - Pulse the granted ready for exactly one cycle with err, then return to IDLE.
- Data holding: if_inst and dm_rdata update only on a successful read's RESP cycle and hold otherwise. A write leaves dm_rdata unchanged.
- Latency, counted from the IDLE grant at cycle 0:
  - Fetch: ready at cycle 11.
  - Data read or write: ready at cycle 9.
  - Error: ready at cycle 1.
- Back-to-back: IDLE always occupies at least one cycle between transactions. A req still high in the cycle after ready counts as a new request.
- No preemption. Requests arriving during a transaction wait. Input changes after grant are ignored.
- mem_en is 0 in IDLE and RESP.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately; after release with no req, mem_en stays 0 and busy=0.
- Fetch at if_addr=0x00, memory bytes 0x30,0xF2,0x0A,0,0,0,0,0,0,0 -> mem_addr 0..9 on cycles 1..10, if_ready at cycle 11, if_inst=0x30F20A00000000000000, if_err=0.
- Write then read: dm_we=1, dm_addr=0x100, dm_wdata=0x1122334455667788 -> bytes 0x88..0x11 written to 0x100..0x107, dm_ready at cycle 9. Then read 0x100 -> dm_rdata=0x1122334455667788.
- Simultaneous if_req and dm_req at the same edge -> data is served first (dm_ready cycle 9), then fetch is granted (IDLE cycle 10, if_ready cycle 21).
- Boundaries:
  - dm_addr=593: granted, 8 beats, err=0.
  - dm_addr=594: dm_ready and dm_err=1 at cycle 1, no mem_en, dm_rdata=0.
  - if_addr=0xFFFFFFFFFFFFFFFC: if_err=1.
- Reset during DWRITE after 3 beats: rst_n low -> mem_en drops at once, bytes addr..addr+2 retained, no dm_ready. After release, a fresh request completes normally.
